// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// ============================================================================
// bit_serializer_pkg : FSM state encoding and default word width.
// Optional macro: SERIALIZER_PARITY_EN adds the PARITY state.
// Revision: 1.0
// ============================================================================
package bit_serializer_pkg;

  localparam int c_DEFAULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1
`ifdef SERIALIZER_PARITY_EN
    ,ST_PARITY = 2'd2
`endif
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// bit_serializer : MSB-first parallel-to-serial converter with a one-word holding register.
// Optional macro: SERIALIZER_PARITY_EN appends an even-parity bit to every word.
// Revision: 1.0
// ============================================================================
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int W = c_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         word_done
);

  localparam int                 c_CNT_W   = (W > 1) ? $clog2(W) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_TOP = c_CNT_W'(W - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  state_t             r_state;
  logic [W-1:0]       r_shift;
  logic [W-1:0]       r_hold;
  logic               r_hold_full;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_sout;
  logic               r_sout_valid;
  logic               r_word_done;
  logic               r_din_ready;
`ifdef SERIALIZER_PARITY_EN
  logic               r_par;
`endif

  logic         w_accept;
  logic         w_idle;
  logic         w_final;
  logic         w_load_hold;
  logic         w_load_din;
  logic         w_load;
  logic         w_hold_full_nxt;
  logic [W-1:0] w_load_word;

  // r_cnt indexes the bit currently on sout; w_final marks the last bit of a word.
  always_comb begin
    w_accept = din_valid && r_din_ready;
    w_idle   = (r_state == ST_IDLE);
`ifdef SERIALIZER_PARITY_EN
    w_final  = (r_state == ST_PARITY);
`else
    w_final  = (r_state == ST_SHIFT) && (r_cnt == '0);
`endif
    w_load_hold = w_final && r_hold_full;
    w_load_din  = w_accept && (w_idle || w_final) && !r_hold_full;
    w_load      = w_load_hold || w_load_din;
    w_load_word = r_hold_full ? r_hold : din;
    if (w_load_hold)
      w_hold_full_nxt = 1'b0;
    else if (w_accept && !w_load_din)
      w_hold_full_nxt = 1'b1;
    else
      w_hold_full_nxt = r_hold_full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_word_done  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (w_load) begin
      r_state      <= ST_SHIFT;
      r_sout       <= w_load_word[W-1];
      r_shift      <= {w_load_word[W-2:0], 1'b0};
      r_cnt        <= c_CNT_TOP;
      r_sout_valid <= 1'b1;
      r_word_done  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_par        <= ^w_load_word;
`endif
    end else begin
      unique case (r_state)
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_sout  <= r_shift[W-1];
            r_shift <= {r_shift[W-2:0], 1'b0};
            r_cnt   <= r_cnt - c_CNT_ONE;
`ifdef SERIALIZER_PARITY_EN
            r_word_done <= 1'b0;
`else
            r_word_done <= (r_cnt == c_CNT_ONE);
`endif
          end else begin
`ifdef SERIALIZER_PARITY_EN
            r_state     <= ST_PARITY;
            r_sout      <= r_par;
            r_word_done <= 1'b1;
`else
            r_state      <= ST_IDLE;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_word_done  <= 1'b0;
`endif
          end
        end
`ifdef SERIALIZER_PARITY_EN
        ST_PARITY: begin
          r_state      <= ST_IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_word_done  <= 1'b0;
        end
`endif
        default: begin
          r_state      <= ST_IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_word_done  <= 1'b0;
        end
      endcase
    end
  end

  // din_ready is registered from the next-cycle holding-register occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_din_ready <= 1'b0;
    end else begin
      r_hold_full <= w_hold_full_nxt;
      r_din_ready <= !w_hold_full_nxt;
      if (w_accept && !w_load_din)
        r_hold <= din;
    end
  end

  assign din_ready  = r_din_ready;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign word_done  = r_word_done;

endmodule
`default_nettype wire

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: W, 8, data word width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 din  input  W  parallel word to serialize.
REQ-005 din_valid  input  1  din holds a valid word.
REQ-006 din_ready  output  1  block can accept a word this cycle.
REQ-007 sout  output  1  serial bit stream to the downstream sequence-detector input.
REQ-008 sout_valid  output  1  sout carries a real data or parity bit this cycle.
REQ-009 word_done  output  1  one-cycle pulse during the final serial bit of each word.

Function
REQ-010 Transfer SHALL occur at a rising edge where din_valid=1 and din_ready=1; no other condition captures din.
REQ-011 Storage SHALL consist of one shift register plus one holding register; din_ready SHALL equal "holding register empty".
REQ-012 Capture while the shifter is IDLE or presenting its final bit SHALL load the word directly into the shifter; otherwise it SHALL load the holding register.
REQ-013 Bit order SHALL be MSB first: after the load edge, sout=din[W-1], then din[W-2] … din[0], one bit per clock, with sout_valid=1.
REQ-014 Latency: first bit SHALL appear in the cycle immediately after the capturing edge when the shifter was idle.
REQ-015 When the shifter finishes and the holding register is full, the next word SHALL start in the very next cycle; there SHALL be no idle gap, and the holding register SHALL empty, with din_ready=1 the same cycle.
REQ-016 FSM states: IDLE (sout=0, sout_valid=0), SHIFT, PARITY (compiled only with REQ-024); IDLE->SHIFT on load; SHIFT->IDLE or SHIFT->SHIFT after bit 0; with parity, SHIFT->PARITY->(IDLE|SHIFT).
REQ-017 Bit counter SHALL be ceil(log2(W)) bits wide, count W-1 down to 0, and never wrap past 0.
REQ-018 word_done SHALL assert exactly once per word, in the cycle of the final bit (data bit 0, or the parity bit when enabled).
REQ-019 Simultaneous final bit plus new capture with the holding register empty SHALL load the shifter directly (REQ-012) and keep din_ready=1.
REQ-020 All outputs SHALL be registered or derived solely from registered state; there SHALL be no combinational din->sout path.

Reset
REQ-021 While rst=1 at an edge: state=IDLE, both registers empty, counter=0, sout=0, sout_valid=0, word_done=0, din_ready=0.
REQ-022 First cycle after rst deasserts: din_ready=1.
REQ-023 Reset mid-word SHALL discard the in-flight and held words entirely; no partial bits SHALL follow.

Configuration
REQ-024 Macro SERIALIZER_PARITY_EN defined: after data bit 0, one extra cycle SHALL present the even-parity bit (XOR of all W word bits) with sout_valid=1; word length is W+1 cycles.
REQ-025 SERIALIZER_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent; word length is W cycles.

Structure
REQ-026 Package bit_serializer_pkg SHALL hold the FSM state typedef and the default-width constant.
REQ-027 The block is a single module; no sub-module is required.

Verification (W=8)
REQ-028 din=8'hC6 accepted while idle -> sout 1,1,0,0,0,1,1,0 over the next 8 cycles, sout_valid=1 throughout; word_done on the 8th bit; the downstream detector sees "110" twice.
REQ-029 din_valid held high with 8'hFF then 8'h00 then 8'hA5 -> 24 contiguous valid bits with no gaps; din_ready deasserts while the holding register is full.
REQ-030 Parity build, din=8'h07 -> 8 data bits then parity bit 1; word_done on the 9th cycle; din=8'h03 gives parity bit 0.
REQ-031 rst asserted at the 4th bit of 8'hF0 with 8'h0F held -> the next cycle shows sout=0, sout_valid=0, din_ready=0; no bits of 8'h0F are ever emitted.
REQ-032 din_valid=0 for 10 cycles after reset -> sout=0, sout_valid=0, word_done=0, din_ready=1 throughout.
